// File: rtl/system_bus_arbiter.sv
// System bus arbiter: round-robin arbitration of several leaders onto a
// shared follower bus, with tag-based follower decode, a single outstanding
// read, read timeout and error completion for unmapped tags.
module system_bus_arbiter #(
  parameter int          Leaders       = 2,
  parameter int          Followers     = 4,
  parameter int          TimeoutCycles = 15,
  parameter logic [31:0] ErrorData     = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [Leaders*32-1:0]    leader_addr,
  input  logic [Leaders*32-1:0]    leader_write_data,
  input  logic [Leaders*4-1:0]     leader_byte_enable,
  input  logic [Leaders-1:0]       leader_read_req,
  input  logic [Leaders-1:0]       leader_write_req,
  output logic [Leaders-1:0]       leader_stall,
  output logic [Leaders*32-1:0]    leader_read_data,
  output logic [Leaders-1:0]       leader_read_data_valid,
  output logic [Leaders-1:0]       leader_error,
  output logic [31:0]              follower_addr,
  output logic [31:0]              follower_write_data,
  output logic [3:0]               follower_byte_enable,
  output logic [Followers-1:0]     follower_read_req,
  output logic [Followers-1:0]     follower_write_req,
  input  logic [Followers*32-1:0]  follower_read_data,
  input  logic [Followers-1:0]     follower_read_data_valid
);

  localparam int         LIDX_W      = (Leaders > 1) ? $clog2(Leaders) : 1;
  localparam logic [4:0] FOLLOWERS_W = 5'(Followers);
  localparam logic [7:0] TIMER_LIMIT = 8'(TimeoutCycles);

  typedef enum logic {IDLE = 1'b0, READ_WAIT = 1'b1} state_t;

  state_t              state_reg;
  logic [LIDX_W-1:0]   rr_ptr_reg;
  logic [LIDX_W-1:0]   owner_reg;
  logic [3:0]          fidx_reg;
  logic [7:0]          timer_reg;
  logic [Leaders-1:0]  err_pend_reg;     // error pulse due next cycle
  logic [Leaders-1:0]  err_rd_pend_reg;  // that error was a read: return ErrorData

  logic                idle_active;
  logic                in_wait;
  logic [Leaders-1:0]  req_any;
  logic                grant_valid;
  logic [LIDX_W-1:0]   grant_idx;
  logic [LIDX_W-1:0]   rr_next;
  logic [Leaders-1:0]  grant_onehot;
  logic                grant_is_read;
  logic [31:0]         grant_addr;
  logic [31:0]         grant_wdata;
  logic [3:0]          grant_be;
  logic [3:0]          grant_tag;
  logic                grant_mapped;
  logic                resp_valid_sel;
  logic [31:0]         resp_data_sel;
  logic                resp_hit;
  logic                timeout_hit;

  // Outputs are held quiet while reset is asserted, so arbitration is gated by rst_n.
  assign idle_active = rst_n && (state_reg == IDLE);
  assign in_wait     = rst_n && (state_reg == READ_WAIT);
  assign req_any     = leader_read_req | leader_write_req;

  // Round-robin search for the first requester at or after rr_ptr.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (idle_active) begin
      for (int k = 0; k < Leaders; k++) begin
        cand = (int'(rr_ptr_reg) + k) % Leaders;
        if (!grant_valid && req_any[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = LIDX_W'(cand);
        end
      end
    end
  end

  assign rr_next = (grant_idx == LIDX_W'(Leaders - 1)) ? '0 : grant_idx + LIDX_W'(1);

  generate
    for (genvar gi = 0; gi < Leaders; gi++) begin : g_grant
      assign grant_onehot[gi] = grant_valid && (grant_idx == LIDX_W'(gi));
    end
  endgenerate

  // Route the granted leader's request onto the shared follower bus.
  always_comb begin
    grant_addr  = '0;
    grant_wdata = '0;
    grant_be    = '0;
    for (int i = 0; i < Leaders; i++) begin
      if (grant_onehot[i]) begin
        grant_addr  = leader_addr[i*32 +: 32];
        grant_wdata = leader_write_data[i*32 +: 32];
        grant_be    = leader_byte_enable[i*4 +: 4];
      end
    end
  end

  // A leader raising both strobes is treated as a read.
  assign grant_is_read = |(leader_read_req & grant_onehot);
  assign grant_tag     = grant_addr[31:28];
  assign grant_mapped  = ({1'b0, grant_tag} < FOLLOWERS_W);

  // Followers see the address with the tag stripped.
  assign follower_addr        = {4'b0000, grant_addr[27:0]};
  assign follower_write_data  = grant_wdata;
  assign follower_byte_enable = grant_be;

  generate
    for (genvar gi = 0; gi < Followers; gi++) begin : g_follower
      assign follower_read_req[gi]  = grant_valid && grant_mapped && grant_is_read &&
                                      (grant_tag == 4'(gi));
      assign follower_write_req[gi] = grant_valid && grant_mapped && !grant_is_read &&
                                      (grant_tag == 4'(gi));
    end
  endgenerate

  // Only the follower that owns the outstanding read may complete it.
  always_comb begin
    resp_valid_sel = 1'b0;
    resp_data_sel  = '0;
    for (int f = 0; f < Followers; f++) begin
      if (fidx_reg == 4'(f)) begin
        resp_valid_sel = follower_read_data_valid[f];
        resp_data_sel  = follower_read_data[f*32 +: 32];
      end
    end
  end

  // A response in the timeout cycle takes priority over the timeout.
  assign resp_hit    = in_wait && resp_valid_sel;
  assign timeout_hit = in_wait && !resp_valid_sel && (timer_reg == TIMER_LIMIT);

  // While a read is outstanding every requester waits; in IDLE only losers wait.
  assign leader_stall = in_wait     ? req_any :
                        idle_active ? (req_any & ~grant_onehot) : '0;

  generate
    for (genvar gi = 0; gi < Leaders; gi++) begin : g_leader
      logic owner_sel;
      assign owner_sel = in_wait && (owner_reg == LIDX_W'(gi));
      assign leader_read_data_valid[gi] = err_rd_pend_reg[gi] ||
                                          (owner_sel && (resp_hit || timeout_hit));
      assign leader_error[gi]           = err_pend_reg[gi] || (owner_sel && timeout_hit);
      assign leader_read_data[gi*32 +: 32] =
          (owner_sel && resp_hit)                           ? resp_data_sel :
          ((owner_sel && timeout_hit) || err_rd_pend_reg[gi]) ? ErrorData     : 32'h0;
    end
  endgenerate

  // Arbiter state machine: pointer advance, read tracking, timer and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      owner_reg       <= '0;
      fidx_reg        <= '0;
      timer_reg       <= '0;
      err_pend_reg    <= '0;
      err_rd_pend_reg <= '0;
    end else begin
      err_pend_reg    <= '0;
      err_rd_pend_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            rr_ptr_reg <= rr_next;
            if (!grant_mapped) begin
              err_pend_reg    <= grant_onehot;
              err_rd_pend_reg <= grant_is_read ? grant_onehot : '0;
            end else if (grant_is_read) begin
              state_reg <= READ_WAIT;
              owner_reg <= grant_idx;
              fidx_reg  <= grant_tag;
              timer_reg <= '0;
            end
          end
        end
        READ_WAIT: begin
          if (resp_valid_sel || (timer_reg == TIMER_LIMIT)) begin
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter with a completion scoreboard:
// expected leader completions are queued with the cycle they are due in.
module tb_system_bus_arbiter;

  logic         clk;
  logic         rst_n;
  logic [63:0]  l_addr;
  logic [63:0]  l_wdata;
  logic [7:0]   l_be;
  logic [1:0]   l_rreq;
  logic [1:0]   l_wreq;
  logic [1:0]   l_stall;
  logic [63:0]  l_rdata;
  logic [1:0]   l_valid;
  logic [1:0]   l_err;
  logic [31:0]  f_addr;
  logic [31:0]  f_wdata;
  logic [3:0]   f_be;
  logic [3:0]   f_rreq;
  logic [3:0]   f_wreq;
  logic [127:0] f_rdata;
  logic [3:0]   f_valid;

  system_bus_arbiter #(
    .Leaders(2), .Followers(4), .TimeoutCycles(15), .ErrorData(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .leader_addr(l_addr), .leader_write_data(l_wdata), .leader_byte_enable(l_be),
    .leader_read_req(l_rreq), .leader_write_req(l_wreq), .leader_stall(l_stall),
    .leader_read_data(l_rdata), .leader_read_data_valid(l_valid), .leader_error(l_err),
    .follower_addr(f_addr), .follower_write_data(f_wdata), .follower_byte_enable(f_be),
    .follower_read_req(f_rreq), .follower_write_req(f_wreq),
    .follower_read_data(f_rdata), .follower_read_data_valid(f_valid)
  );

  typedef struct {
    int unsigned due;
    logic [1:0]  v;
    logic [1:0]  e;
    logic [63:0] d;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  exp_t        push_x;
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned cyc = 0;
  int unsigned g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cpl(input int unsigned due, input logic [1:0] v,
                            input logic [1:0] e, input logic [63:0] d);
    push_x.due = due;
    push_x.v   = v;
    push_x.e   = e;
    push_x.d   = d;
    sb.push_back(push_x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 64'(l_stall), 64'h0);
    check({tag, "_fwreq"}, 64'(f_wreq), 64'h0);
    check({tag, "_frreq"}, 64'(f_rreq), 64'h0);
    check({tag, "_faddr"}, 64'(f_addr), 64'h0);
    check({tag, "_vld_err"}, 64'({l_valid, l_err}), 64'h0);
    check({tag, "_rdata"}, l_rdata, 64'h0);
  endtask

  // Completion monitor: due entries are compared, otherwise the leader side must be quiet.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_x = sb.pop_front();
      $display("cyc %0d completion: valid=%b error=%b data=%h", cyc, l_valid, l_err, l_rdata);
      check("cpl_valid", 64'(l_valid), 64'(mon_x.v));
      check("cpl_error", 64'(l_err), 64'(mon_x.e));
      check("cpl_data", l_rdata, mon_x.d);
    end else begin
      check("quiet_vld_err", 64'({l_valid, l_err}), 64'h0);
      check("quiet_rdata", l_rdata, 64'h0);
    end
  end

  initial begin
    rst_n   = 1'b0;
    l_addr  = '0;
    l_wdata = '0;
    l_be    = '0;
    l_rreq  = '0;
    l_wreq  = '0;
    f_rdata = '0;
    f_valid = '0;
    // Requests during reset must not reach the followers.
    l_wreq  = 2'b01;
    l_addr[31:0] = 32'h1000_0000;
    step();
    step();
    #1;
    check_all_zero("reset");
    l_wreq = '0;
    rst_n  = 1'b1;
    step();

    // Two leaders writing to follower 1 every cycle alternate grants.
    l_addr  = {32'h1000_0104, 32'h1000_0004};
    l_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    l_be    = 8'hF3;
    l_wreq  = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      $display("cyc %0d write grant: fwreq=%b stall=%b wdata=%h", cyc, f_wreq, l_stall, f_wdata);
      check("rr_fwreq", 64'(f_wreq), 64'h2);
      check("rr_wdata", 64'(f_wdata), (c % 2 == 1) ? 64'hBBBB_0001 : 64'hAAAA_0000);
      check("rr_stall", 64'(l_stall), (c % 2 == 1) ? 64'h1 : 64'h2);
      check("rr_faddr", 64'(f_addr), (c % 2 == 1) ? 64'h0000_0104 : 64'h0000_0004);
      check("rr_be", 64'(f_be), (c % 2 == 1) ? 64'hF : 64'h3);
      step();
    end
    l_wreq = '0;
    step();

    // L1 read of follower 2, answered three cycles later; L0 waits throughout.
    l_addr[63:32] = 32'h2000_0010;
    l_rreq        = 2'b10;
    g = cyc;
    #1;
    $display("cyc %0d read issue: frreq=%b faddr=%h", cyc, f_rreq, f_addr);
    check("rd_frreq", 64'(f_rreq), 64'h4);
    check("rd_faddr", 64'(f_addr), 64'h0000_0010);
    check("rd_stall", 64'(l_stall), 64'h0);
    step();
    l_rreq       = '0;
    l_addr[31:0] = 32'h0000_0040;
    l_wdata[31:0] = 32'h0C0C_0C0C;
    l_wreq       = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin
        f_valid            = 4'b1000;
        f_rdata[127:96]    = 32'hFFFF_0000;
      end
      if (k == 3) begin
        f_valid            = 4'b0100;
        f_rdata[95:64]     = 32'h1234_5678;
        expect_cpl(cyc, 2'b10, 2'b00, {32'h1234_5678, 32'h0});
      end
      #1;
      check("wait_stall", 64'(l_stall), 64'h1);
      check("wait_fstrobes", 64'({f_rreq, f_wreq}), 64'h0);
      step();
      f_valid = '0;
    end
    #1;
    check("resume_fwreq", 64'(f_wreq), 64'h1);
    check("resume_stall", 64'(l_stall), 64'h0);
    step();
    l_wreq = '0;
    step();

    // Unmapped tags: read returns ErrorData with error, write returns error only.
    l_addr[31:0] = 32'h5000_0000;
    l_rreq       = 2'b01;
    #1;
    check("unmap_rd_fstrobes", 64'({f_rreq, f_wreq}), 64'h0);
    expect_cpl(cyc + 1, 2'b01, 2'b01, {32'h0, 32'hDEAD_BEEF});
    step();
    l_rreq        = '0;
    l_addr[63:32] = 32'h7000_0000;
    l_wreq        = 2'b10;
    #1;
    check("unmap_wr_fstrobes", 64'({f_rreq, f_wreq}), 64'h0);
    expect_cpl(cyc + 1, 2'b00, 2'b10, 64'h0);
    step();
    l_wreq = '0;
    step();

    // Read to a silent follower times out 15 cycles after entering READ_WAIT.
    l_addr[31:0] = 32'h3000_0000;
    l_rreq       = 2'b01;
    g = cyc;
    #1;
    check("to_frreq", 64'(f_rreq), 64'h8);
    expect_cpl(g + 16, 2'b01, 2'b01, {32'h0, 32'hDEAD_BEEF});
    step();
    l_rreq = '0;
    while (cyc < g + 18) step();

    // Response arriving in the timeout cycle wins and carries real data.
    l_addr[63:32] = 32'h3000_0020;
    l_rreq        = 2'b10;
    g = cyc;
    step();
    l_rreq = '0;
    while (cyc < g + 16) step();
    f_valid          = 4'b1000;
    f_rdata[127:96]  = 32'hCAFE_0001;
    expect_cpl(cyc, 2'b10, 2'b00, {32'hCAFE_0001, 32'h0});
    step();
    f_valid = '0;
    step();

    // Reset in the middle of READ_WAIT abandons the read.
    l_addr[63:32] = 32'h2000_0000;
    l_rreq        = 2'b10;
    step();
    l_rreq = '0;
    step();
    rst_n        = 1'b0;
    l_addr[31:0] = 32'h0000_0000;
    l_wreq       = 2'b01;
    #1;
    check_all_zero("mid_rst1");
    step();
    check_all_zero("mid_rst2");
    step();
    rst_n          = 1'b1;
    l_wreq         = '0;
    f_valid        = 4'b0100;
    f_rdata[95:64] = 32'h0BAD_0BAD;
    #1;
    check("late_resp_valid", 64'(l_valid), 64'h0);
    check("late_resp_frreq", 64'(f_rreq), 64'h0);
    step();
    f_valid = '0;
    l_addr  = {32'h0000_0008, 32'h0000_0004};
    l_wdata = {32'h1111_1111, 32'h2222_2222};
    l_wreq  = 2'b11;
    #1;
    $display("cyc %0d post-reset grant: stall=%b wdata=%h", cyc, l_stall, f_wdata);
    check("post_rst_stall", 64'(l_stall), 64'h2);
    check("post_rst_wdata", 64'(f_wdata), 64'h2222_2222);
    check("post_rst_fwreq", 64'(f_wreq), 64'h1);
    step();
    l_wreq = '0;
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
